frog_move_controller: RTL and testbench
=======================================

// Module: frog_move_controller
// PURPOSE
//  Upstream sequencer for the sprite draw datapath/control pair. Turns player key
//  presses into frog position updates. For each move it issues an erase pass at the
//  old position, then a draw pass at the new one, through the go/plot_done handshake.
//  Outputs frog_x/frog_y are the sprite origin used by the plotter offsets.
// PARAMETERS
//  WIDTH_X   9    bit width of frog_x
//  WIDTH_Y   9    bit width of frog_y
//  START_X   76   x origin after reset
//  START_Y   112  y origin after reset
//  STEP_X    8    pixels per left/right move
//  STEP_Y    8    pixels per up/down move
//  X_MAX     152  largest legal frog_x (min is 0)
//  Y_MAX     112  largest legal frog_y (min is 0 = goal row)
//  COOLDOWN  4    idle cycles enforced after each completed draw (>=1)
// PORTS
//  clk        in   1        system clock, all state on posedge
//  reset      in   1        asynchronous, active-low reset
//  key_up     in   1        level, already synchronised to clk
//  key_down   in   1        level, already synchronised to clk
//  key_left   in   1        level, already synchronised to clk
//  key_right  in   1        level, already synchronised to clk
//  plot_done  in   1        one-cycle pulse from plotter: current pass finished
//  go         out  1        one-cycle request to start a plot pass
//  erase      out  1        1 = current pass is an erase (bg colour), 0 = frog sprite
//  frog_x     out  WIDTH_X  current frog origin x
//  frog_y     out  WIDTH_Y  current frog origin y
//  busy       out  1        1 whenever state != S_IDLE
//  goal       out  1        one-cycle pulse: frog reached y==0
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=S_DRAW_REQ, frog_x=START_X, frog_y=START_Y.
//   - go=0, erase=0, goal=0; key edge registers=0; cooldown counter=0.
//   - A reset during any pass abandons it; no partial update survives.
//  Key edges:
//   - Each key registered once; press = level 1 now, 0 last cycle.
//   - Edges acted on only in S_IDLE; edges in other states are dropped, not queued.
//   - Simultaneous edges: priority up > down > left > right; only one applied.
//  FSM (registered outputs; go is high exactly one cycle per REQ state):
//   - S_IDLE: a valid move goes to S_ERASE_REQ.
//     - A move is valid if the target stays within 0..X_MAX / 0..Y_MAX.
//     - An out-of-range move is ignored: stay in S_IDLE, no go.
//   - S_ERASE_REQ: go=1, erase=1; latch pending target; next S_ERASE_WAIT.
//   - S_ERASE_WAIT: erase=1; on plot_done go to S_UPDATE.
//   - S_UPDATE: frog_x/frog_y <= target (1 cycle); goal=1 if the new y==0;
//     next S_DRAW_REQ.
//   - S_DRAW_REQ: go=1, erase=0; next S_DRAW_WAIT.
//   - S_DRAW_WAIT: on plot_done go to S_COOLDOWN with the counter loaded to COOLDOWN-1.
//   - S_COOLDOWN: decrement the counter; at 0 go to S_IDLE.
//  Handshake and position rules:
//   - plot_done outside a WAIT state is ignored.
//   - plot_done in the same cycle as go is not counted.
//   - frog_x/frog_y change only in S_UPDATE, so they are stable for a whole pass.
//   - Arithmetic is unsigned at WIDTH_X/WIDTH_Y; bounds are checked before the
//     step, so values never wrap.
//     - up: y-STEP_Y, legal if y>=STEP_Y.
//     - down: legal if y+STEP_Y<=Y_MAX.
//     - left and right: same rules on x with STEP_X and X_MAX.
//  Latency: key edge at cycle n -> go(erase) at n+2.
//   Draw go comes 2 cycles after the erase plot_done.
// TESTING
//  1. Release reset: go=1/erase=0 in first cycle, frog=(76,112); plot_done 3 cycles
//     later -> busy stays 1 for 4 more cycles, then 0.
//  2. From idle at (76,112), key_up pulse: go with erase=1; plot_done; frog_y=104;
//     then go with erase=0; frog_x unchanged at 76.
//  3. At (0,112): key_left -> no go, busy=0; key_down -> no go; frog unchanged.
//  4. key_up and key_right rise together -> only y decrements (112->104), x=76.
//  5. Hold key_right high for 50 cycles -> exactly one move (76->84).
//     Pressing key_right during S_DRAW_WAIT -> ignored.
//  6. From (76,8), key_up -> frog_y=0 and goal pulses for exactly 1 cycle in S_UPDATE.
//     Assert reset mid-S_ERASE_WAIT -> frog=(76,112), go=0, then a fresh draw pass.

Source files
------------

// File: rtl/frog_move_controller_if.sv
// Handshake and position bundle between the frog move controller
// and the key front end / sprite plotter.
interface frog_move_controller_if #(
  parameter int WIDTH_X = 9,
  parameter int WIDTH_Y = 9
);
  logic               key_up;
  logic               key_down;
  logic               key_left;
  logic               key_right;
  logic               plot_done;
  logic               go;
  logic               erase;
  logic [WIDTH_X-1:0] frog_x;
  logic [WIDTH_Y-1:0] frog_y;
  logic               busy;
  logic               goal;

  modport master (
    input  key_up,
    input  key_down,
    input  key_left,
    input  key_right,
    input  plot_done,
    output go,
    output erase,
    output frog_x,
    output frog_y,
    output busy,
    output goal
  );

  modport slave (
    output key_up,
    output key_down,
    output key_left,
    output key_right,
    output plot_done,
    input  go,
    input  erase,
    input  frog_x,
    input  frog_y,
    input  busy,
    input  goal
  );
endinterface

// File: rtl/frog_move_controller.sv
// Frog move sequencer: key edges become an erase pass at the old
// origin followed by a draw pass at the new one.
module frog_move_controller #(
  parameter int unsigned WIDTH_X  = 9,
  parameter int unsigned WIDTH_Y  = 9,
  parameter int unsigned START_X  = 76,
  parameter int unsigned START_Y  = 112,
  parameter int unsigned STEP_X   = 8,
  parameter int unsigned STEP_Y   = 8,
  parameter int unsigned X_MAX    = 152,
  parameter int unsigned Y_MAX    = 112,
  parameter int unsigned COOLDOWN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  frog_move_controller_if.master bus
);

  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [WIDTH_X:0] SX = (WIDTH_X+1)'(STEP_X);
  localparam logic [WIDTH_X:0] XM = (WIDTH_X+1)'(X_MAX);
  localparam logic [WIDTH_Y:0] SY = (WIDTH_Y+1)'(STEP_Y);
  localparam logic [WIDTH_Y:0] YM = (WIDTH_Y+1)'(Y_MAX);

  localparam logic [WIDTH_X-1:0] X0 = WIDTH_X'(START_X);
  localparam logic [WIDTH_Y-1:0] Y0 = WIDTH_Y'(START_Y);
  localparam logic [CW-1:0]      CD = CW'(COOLDOWN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_REQ,
    S_ERASE_WAIT,
    S_UPDATE,
    S_DRAW_REQ,
    S_DRAW_WAIT,
    S_COOLDOWN
  } state_t;

  state_t             state;
  logic               go;
  logic               erase;
  logic               goal;
  logic [WIDTH_X-1:0] frog_x;
  logic [WIDTH_Y-1:0] frog_y;
  logic [WIDTH_X-1:0] tgt_x;
  logic [WIDTH_Y-1:0] tgt_y;
  logic [CW-1:0]      cnt;

  logic [3:0]         keys;
  logic [3:0]         key_q;
  logic [3:0]         edge_r;
  logic [3:0]         sel;
  logic               mv_ok;
  logic [WIDTH_X-1:0] nx;
  logic [WIDTH_Y-1:0] ny;

  assign keys = {bus.key_right, bus.key_left,
                 bus.key_down, bus.key_up};

  // Edges are only captured while idle so presses
  // during a pass are dropped rather than queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q  <= '0;
      edge_r <= '0;
    end else begin
      key_q  <= keys;
      edge_r <= (state == S_IDLE) ? (keys & ~key_q) : '0;
    end
  end

  assign sel[0] = edge_r[0];
  assign sel[1] = edge_r[1] & ~edge_r[0];
  assign sel[2] = edge_r[2] & ~|edge_r[1:0];
  assign sel[3] = edge_r[3] & ~|edge_r[2:0];

  // Bounds are checked one bit wider so the step never wraps.
  always_comb begin
    mv_ok = 1'b0;
    nx    = frog_x;
    ny    = frog_y;
    unique case (1'b1)
      sel[0]: begin
        mv_ok = ({1'b0, frog_y} >= SY);
        ny    = frog_y - SY[WIDTH_Y-1:0];
      end
      sel[1]: begin
        mv_ok = ({1'b0, frog_y} + SY <= YM);
        ny    = frog_y + SY[WIDTH_Y-1:0];
      end
      sel[2]: begin
        mv_ok = ({1'b0, frog_x} >= SX);
        nx    = frog_x - SX[WIDTH_X-1:0];
      end
      sel[3]: begin
        mv_ok = ({1'b0, frog_x} + SX <= XM);
        nx    = frog_x + SX[WIDTH_X-1:0];
      end
      default: ;
    endcase
  end

  // Out of reset the REQ state is entered with go low,
  // so it raises go itself and leaves on the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_DRAW_REQ;
      go     <= 1'b0;
      erase  <= 1'b0;
      goal   <= 1'b0;
      frog_x <= X0;
      frog_y <= Y0;
      tgt_x  <= X0;
      tgt_y  <= Y0;
      cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (mv_ok) begin
            tgt_x <= nx;
            tgt_y <= ny;
            go    <= 1'b1;
            erase <= 1'b1;
            state <= S_ERASE_REQ;
          end
        end
        S_ERASE_REQ: begin
          if (go) begin
            go    <= 1'b0;
            state <= S_ERASE_WAIT;
          end else begin
            go    <= 1'b1;
          end
        end
        S_ERASE_WAIT: begin
          if (bus.plot_done) begin
            erase <= 1'b0;
            goal  <= (tgt_y == '0);
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          frog_x <= tgt_x;
          frog_y <= tgt_y;
          goal   <= 1'b0;
          go     <= 1'b1;
          state  <= S_DRAW_REQ;
        end
        S_DRAW_REQ: begin
          erase <= 1'b0;
          if (go) begin
            go    <= 1'b0;
            state <= S_DRAW_WAIT;
          end else begin
            go    <= 1'b1;
          end
        end
        S_DRAW_WAIT: begin
          if (bus.plot_done) begin
            cnt   <= CD;
            state <= S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt   <= cnt - 1'b1;
          end
        end
        default: begin
          go    <= 1'b0;
          erase <= 1'b0;
          goal  <= 1'b0;
          state <= S_DRAW_REQ;
        end
      endcase
    end
  end

  assign bus.go     = go;
  assign bus.erase  = erase;
  assign bus.goal   = goal;
  assign bus.frog_x = frog_x;
  assign bus.frog_y = frog_y;
  assign bus.busy   = (state != S_IDLE);

endmodule

// File: tb/tb_frog_move_controller.sv
// Randomized bench for frog_move_controller against a
// position/priority model of frog moves and pass timing.
module tb_frog_move_controller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  frog_move_controller_if #(.WIDTH_X(9), .WIDTH_Y(9)) bus ();

  frog_move_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mx    = 76;
  int my    = 112;

  task automatic set_keys(input logic [3:0] k);
    bus.key_up    = k[0];
    bus.key_down  = k[1];
    bus.key_left  = k[2];
    bus.key_right = k[3];
  endtask

  // k: bit0 up, bit1 down, bit2 left, bit3 right
  function automatic bit model_move(
    input  logic [3:0] k,
    input  int         x,
    input  int         y,
    output int         nx,
    output int         ny
  );
    nx = x;
    ny = y;
    if (k[0]) begin
      ny = y - 8;
      return y >= 8;
    end
    if (k[1]) begin
      ny = y + 8;
      return y + 8 <= 112;
    end
    if (k[2]) begin
      nx = x - 8;
      return x >= 8;
    end
    if (k[3]) begin
      nx = x + 8;
      return x + 8 <= 152;
    end
    return 1'b0;
  endfunction

  task automatic do_move(
    input logic [3:0] k,
    input bit         dup_done,
    input bit         poke,
    input int         d1,
    input int         d2
  );
    bit mv;
    int nx, ny;
    mv = model_move(k, mx, my, nx, ny);
    set_keys(k);
    @(negedge clk);
    set_keys(4'b0);
    n_cmp++;
    if (bus.go !== 1'b0) begin
      n_bad++;
      $display("FAIL early_go k=%b: go=%b want 0", k, bus.go);
    end
    @(negedge clk);
    if (!mv) begin
      repeat (2) @(negedge clk);
      n_cmp++;
      if (bus.go !== 1'b0 || bus.busy !== 1'b0 ||
          bus.frog_x !== 9'(mx) || bus.frog_y !== 9'(my)) begin
        n_bad++;
        $display("FAIL no_move k=%b: go=%b busy=%b xy=%0d,%0d want 0 0 %0d,%0d",
                 k, bus.go, bus.busy, bus.frog_x, bus.frog_y, mx, my);
      end
      return;
    end
    n_cmp++;
    if (bus.go !== 1'b1 || bus.erase !== 1'b1 ||
        bus.frog_x !== 9'(mx) || bus.frog_y !== 9'(my)) begin
      n_bad++;
      $display("FAIL erase_go k=%b: go=%b erase=%b xy=%0d,%0d want 1 1 %0d,%0d",
               k, bus.go, bus.erase, bus.frog_x, bus.frog_y, mx, my);
    end
    if (dup_done) bus.plot_done = 1'b1;
    @(negedge clk);
    bus.plot_done = 1'b0;
    n_cmp++;
    if (bus.go !== 1'b0 || bus.erase !== 1'b1 ||
        bus.busy !== 1'b1 || bus.goal !== 1'b0) begin
      n_bad++;
      $display("FAIL erase_wait k=%b: go=%b erase=%b busy=%b goal=%b want 0 1 1 0",
               k, bus.go, bus.erase, bus.busy, bus.goal);
    end
    repeat (d1) @(negedge clk);
    bus.plot_done = 1'b1;
    @(negedge clk);
    bus.plot_done = 1'b0;
    n_cmp++;
    if (bus.goal !== (ny == 0) || bus.erase !== 1'b0 ||
        bus.frog_x !== 9'(mx) || bus.frog_y !== 9'(my)) begin
      n_bad++;
      $display("FAIL update k=%b: goal=%b erase=%b xy=%0d,%0d want %b 0 %0d,%0d",
               k, bus.goal, bus.erase, bus.frog_x, bus.frog_y,
               ny == 0, mx, my);
    end
    mx = nx;
    my = ny;
    @(negedge clk);
    n_cmp++;
    if (bus.go !== 1'b1 || bus.erase !== 1'b0 || bus.goal !== 1'b0 ||
        bus.frog_x !== 9'(mx) || bus.frog_y !== 9'(my)) begin
      n_bad++;
      $display("FAIL draw_go k=%b: go=%b erase=%b goal=%b xy=%0d,%0d want 1 0 0 %0d,%0d",
               k, bus.go, bus.erase, bus.goal, bus.frog_x, bus.frog_y, mx, my);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.go !== 1'b0) begin
      n_bad++;
      $display("FAIL draw_wait k=%b: go=%b want 0", k, bus.go);
    end
    if (poke) begin
      set_keys(4'b1000);
      @(negedge clk);
      set_keys(4'b0);
    end
    repeat (d2) @(negedge clk);
    bus.plot_done = 1'b1;
    @(negedge clk);
    bus.plot_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cooldown k=%b: busy=%b want 1", k, bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.go !== 1'b0) begin
      n_bad++;
      $display("FAIL idle k=%b: busy=%b go=%b want 0 0", k, bus.busy, bus.go);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.go !== 1'b0 ||
        bus.frog_x !== 9'(mx) || bus.frog_y !== 9'(my)) begin
      n_bad++;
      $display("FAIL settle k=%b: busy=%b go=%b xy=%0d,%0d want 0 0 %0d,%0d",
               k, bus.busy, bus.go, bus.frog_x, bus.frog_y, mx, my);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    set_keys(4'b0);
    bus.plot_done = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.go !== 1'b0 || bus.erase !== 1'b0 || bus.goal !== 1'b0 ||
        bus.busy !== 1'b1 || bus.frog_x !== 9'd76 || bus.frog_y !== 9'd112) begin
      n_bad++;
      $display("FAIL reset_state: go=%b erase=%b goal=%b busy=%b xy=%0d,%0d want 0 0 0 1 76,112",
               bus.go, bus.erase, bus.goal, bus.busy, bus.frog_x, bus.frog_y);
    end
    reset = 1'b1;
    mx = 76;
    my = 112;
    @(negedge clk);
    n_cmp++;
    if (bus.go !== 1'b1 || bus.erase !== 1'b0) begin
      n_bad++;
      $display("FAIL first_draw: go=%b erase=%b want 1 0", bus.go, bus.erase);
    end
    repeat (3) @(negedge clk);
    bus.plot_done = 1'b1;
    @(negedge clk);
    bus.plot_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_cooldown%0d: busy=%b want 1", i, bus.busy);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b want 0", bus.busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_up;
    do_move(4'b0001, 1'b0, 1'b0, 2, 2);
  endtask

  task automatic test_priority;
    do_move(4'b1001, 1'b0, 1'b0, 1, 0);
    do_move(4'b0110, 1'b0, 1'b0, 0, 1);
  endtask

  task automatic test_bounds;
    while (mx >= 8) do_move(4'b0100, 1'b0, 1'b0, 0, 0);
    while (my + 8 <= 112) do_move(4'b0010, 1'b0, 1'b0, 0, 0);
    do_move(4'b0100, 1'b0, 1'b0, 0, 0);
    do_move(4'b0010, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_hold;
    int n_go = 0;
    int pd   = 0;
    int ex, ey;
    bit mv;
    mv = model_move(4'b1000, mx, my, ex, ey);
    set_keys(4'b1000);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 50) set_keys(4'b0);
      bus.plot_done = 1'b0;
      if (bus.go === 1'b1) begin
        n_go++;
        pd = 3;
      end else if (pd > 0) begin
        pd--;
        if (pd == 0) bus.plot_done = 1'b1;
      end
    end
    @(negedge clk);
    bus.plot_done = 1'b0;
    if (mv) begin
      mx = ex;
      my = ey;
    end
    n_cmp++;
    if (n_go != (mv ? 2 : 0) || bus.frog_x !== 9'(mx) || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold: gos=%0d x=%0d busy=%b want %0d %0d 0",
               n_go, bus.frog_x, bus.busy, mv ? 2 : 0, mx);
    end
    do_move(4'b0001, 1'b0, 1'b1, 0, 2);
  endtask

  task automatic test_goal;
    while (my > 8) do_move(4'b0001, 1'b0, 1'b0, 0, 0);
    do_move(4'b0001, 1'b0, 1'b0, 1, 0);
    n_cmp++;
    if (bus.frog_y !== 9'd0 || bus.goal !== 1'b0) begin
      n_bad++;
      $display("FAIL goal_row: y=%0d goal=%b want 0 0", bus.frog_y, bus.goal);
    end
  endtask

  task automatic test_reset_mid;
    set_keys(4'b0010);
    @(negedge clk);
    set_keys(4'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.go !== 1'b1 || bus.erase !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_erase_go: go=%b erase=%b want 1 1", bus.go, bus.erase);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    mx = 76;
    my = 112;
    n_cmp++;
    if (bus.go !== 1'b0 || bus.erase !== 1'b0 ||
        bus.frog_x !== 9'd76 || bus.frog_y !== 9'd112) begin
      n_bad++;
      $display("FAIL mid_reset: go=%b erase=%b xy=%0d,%0d want 0 0 76,112",
               bus.go, bus.erase, bus.frog_x, bus.frog_y);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.go !== 1'b1 || bus.erase !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_redraw: go=%b erase=%b want 1 0", bus.go, bus.erase);
    end
    @(negedge clk);
    bus.plot_done = 1'b1;
    @(negedge clk);
    bus.plot_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_cooldown: busy=%b want 1", bus.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_idle: busy=%b want 0", bus.busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] k;
      k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        bus.plot_done = 1'b1;
        @(negedge clk);
        bus.plot_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.go !== 1'b0) begin
          n_bad++;
          $display("FAIL stray_done it=%0d: busy=%b go=%b want 0 0",
                   i, bus.busy, bus.go);
        end
      end
      do_move(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: no finish after 500us");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic_up;
    test_priority;
    test_bounds;
    test_hold;
    test_goal;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
